// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive controller
// Contents: receiver state enum, data width, bit counter width, legal prescale ratios.
`timescale 1ns/1ps
package uart_rx_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int BIT_CNT_W   = $clog2(DATA_WIDTH);

    localparam int PRESCALE_X8  = 8;
    localparam int PRESCALE_X16 = 16;
    localparam int PRESCALE_X32 = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversampling edge counter and data bit counter
// Ports: CLK, RST (async, active-low); enable runs the edge counter (held at 0 when low);
//        bit_clr zeroes bit_cnt; bit_inc advances bit_cnt at bit-end; Prescale sets the
//        bit period; edge_cnt, bit_cnt and the bit_end strobe are outputs.
`timescale 1ns/1ps
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int Prescale_width = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic                      bit_clr,
    input  logic                      bit_inc,
    input  logic [Prescale_width-1:0] Prescale,
    output logic [Prescale_width-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]      bit_cnt,
    output logic                      bit_end
);

    logic [Prescale_width-1:0] edge_cnt_q, edge_cnt_d;
    logic [Prescale_width-1:0] last_edge;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

    assign last_edge = Prescale - Prescale_width'(1);
    assign bit_end   = enable && (edge_cnt_q == last_edge);

    always_comb begin
        edge_cnt_d = '0;
        if (enable && !bit_end) begin
            edge_cnt_d = edge_cnt_q + Prescale_width'(1);
        end

        bit_cnt_d = bit_cnt_q;
        if (bit_clr) begin
            bit_cnt_d = '0;
        end else if (bit_inc && bit_end) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: framing FSM, parity check, deserializer
// Ports: CLK, RST (async, active-low); RX_IN serial line; Prescale, PAR_EN, PAR_TYP config;
//        sampled_bit from the sampler; edge_cnt / dat_samp_en drive the sampler;
//        P_DATA + data_valid deliver bytes; par_err / stp_err flag bad frames.
// Option: UART_RX_ERR_CNT_EN adds err_cnt, a saturating count of error pulses.
`timescale 1ns/1ps
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int Prescale_width = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [Prescale_width-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      sampled_bit,
    output logic [Prescale_width-1:0] edge_cnt,
    output logic                      dat_samp_en,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]                err_cnt
`endif
);

    rx_state_e             state_q, state_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  discard_q, discard_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  bit_clr, bit_inc, bit_end;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    assign dat_samp_en = (state_q != ST_IDLE);

    uart_rx_edge_bit_cnt #(
        .Prescale_width (Prescale_width)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (dat_samp_en),
        .bit_clr  (bit_clr),
        .bit_inc  (bit_inc),
        .Prescale (Prescale),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    always_comb begin
        state_d      = state_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        discard_d    = discard_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        bit_clr      = 1'b0;
        bit_inc      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_d   = ST_START;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    discard_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    if (!sampled_bit) begin
                        state_d = ST_DATA;
                        bit_clr = 1'b1;
                    end else begin
                        // A start bit that votes high was line noise; drop it silently.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    // LSB arrives first, so each new bit enters at the top and moves right.
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    bit_inc = 1'b1;
                    if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    if (sampled_bit != ((^shift_q) ^ par_typ_q)) begin
                        par_err_d = 1'b1;
                        discard_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!sampled_bit) begin
                        stp_err_d = 1'b1;
                    end else if (!discard_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                    discard_d = 1'b0;
                    // A low line at the stop bit-end is the next frame's start edge.
                    if (!RX_IN) begin
                        state_d   = ST_START;
                        par_en_d  = PAR_EN;
                        par_typ_d = PAR_TYP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            discard_q    <= 1'b0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            discard_q    <= discard_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts from the pulse requests so the count moves in the same cycle as the pulse.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((par_err_d || stp_err_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int MAXC = 32768;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic [5:0] edge_cnt;
    logic       dat_samp_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    uart_rx_ctrl #(.Prescale_width(6)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .edge_cnt    (edge_cnt),
        .dat_samp_en (dat_samp_en),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Expected behaviour per cycle, filled in from frame timing arithmetic.
    bit       exp_dv  [MAXC];
    bit       exp_pe  [MAXC];
    bit       exp_se  [MAXC];
    bit       exp_en  [MAXC];
    bit [7:0] exp_edge[MAXC];
    bit       pd_set  [MAXC];
    bit [7:0] pd_val  [MAXC];
    bit       err_inc [MAXC];
    bit       exp_rst [MAXC];

    int       n_chk  = 0;
    int       n_fail = 0;
    bit       chk_on = 1'b0;
    bit [7:0] model_pdata = 8'h00;
    int       model_err   = 0;

    int dv_n, pe_n, se_n, en_n;
    int first_dv, last_dv, last_pe, last_se;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_on) begin
            if (exp_rst[cyc]) begin
                model_pdata = 8'h00;
                model_err   = 0;
            end
            if (pd_set[cyc]) model_pdata = pd_val[cyc];
            if (err_inc[cyc] && model_err != 255) model_err++;
            check("edge_cnt",    int'(edge_cnt),    int'(exp_edge[cyc]));
            check("dat_samp_en", int'(dat_samp_en), int'(exp_en[cyc]));
            check("data_valid",  int'(data_valid),  int'(exp_dv[cyc]));
            check("par_err",     int'(par_err),     int'(exp_pe[cyc]));
            check("stp_err",     int'(stp_err),     int'(exp_se[cyc]));
            check("P_DATA",      int'(P_DATA),      int'(model_pdata));
`ifdef UART_RX_ERR_CNT_EN
            check("err_cnt",     int'(err_cnt),     model_err);
`endif
        end
        if (data_valid) begin
            if (dv_n == 0) first_dv = cyc;
            dv_n++;
            last_dv = cyc;
        end
        if (par_err) begin pe_n++; last_pe = cyc; end
        if (stp_err) begin se_n++; last_se = cyc; end
        if (dat_samp_en) en_n++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        dv_n = 0; pe_n = 0; se_n = 0; en_n = 0;
        first_dv = -1; last_dv = -1; last_pe = -1; last_se = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            RX_IN       = 1'b1;
            sampled_bit = 1'($urandom % 2);
        end
    endtask

    task automatic do_reset();
        int c;
        c = cyc;
        for (int i = c; i < MAXC; i++) begin
            exp_dv[i] = 0; exp_pe[i] = 0; exp_se[i] = 0; exp_en[i] = 0;
            exp_edge[i] = 0; pd_set[i] = 0; err_inc[i] = 0;
        end
        exp_rst[c]     = 1;
        exp_rst[c + 1] = 1;
        RST   = 1'b0;
        RX_IN = 1'b1;
        step();
        step();
        RST = 1'b1;
    endtask

    // Call in the cycle that is to be t0. Returns in the stop bit's last cycle.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input bit [7:0] d,
                              input bit badp, input bit stopv, input bit b2b,
                              input int abort, output int t0);
        bit   bits[11];
        int   nb, e, n, ln;
        bit   par, v;
        nb   = pen ? 11 : 10;
        par  = (^d) ^ ptyp ^ (pen & badp);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        if (pen) bits[9] = par;
        bits[nb - 1] = stopv;

        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        RX_IN    = 1'b0;
        t0       = cyc;

        e = t0 + nb * p;
        for (int c = t0 + 1; c <= e; c++) begin
            exp_en[c]   = 1;
            exp_edge[c] = 8'((c - t0 - 1) % p);
        end
        if (pen && badp) begin
            exp_pe[t0 + 10 * p + 1]  = 1;
            err_inc[t0 + 10 * p + 1] = 1;
        end
        if (!stopv) begin
            exp_se[e + 1]  = 1;
            err_inc[e + 1] = 1;
        end else if (!(pen && badp)) begin
            exp_dv[e + 1] = 1;
            pd_set[e + 1] = 1;
            pd_val[e + 1] = d;
        end

        n = 0;
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < p; j++) begin
                step();
                n++;
                v  = bits[k];
                ln = v;
                if (k == nb - 1) ln = (j == p - 1) ? !b2b : stopv;
                sampled_bit = v;
                RX_IN       = 1'(ln);
                if (abort != 0 && n == abort) begin
                    do_reset();
                    return;
                end
            end
        end
    endtask

    task automatic send_glitch(input int p, input int len, output int t0);
        Prescale    = 6'(p);
        RX_IN       = 1'b0;
        sampled_bit = 1'b1;
        t0          = cyc;
        for (int c = t0 + 1; c <= t0 + p; c++) begin
            exp_en[c]   = 1;
            exp_edge[c] = 8'((c - t0 - 1) % p);
        end
        for (int j = 0; j < p; j++) begin
            step();
            RX_IN       = (j + 1 < len) ? 1'b0 : 1'b1;
            sampled_bit = 1'b1;
        end
    endtask

    function automatic int pick_p();
        case ($urandom % 3)
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  t0, t1, p;
        bit  pen, ptyp, b2b, prev_b2b;

        clear_mon();
        RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        sampled_bit = 1'b1;
        step();
        step();
        @(negedge CLK);
        check("rst_edge_cnt",    int'(edge_cnt),    0);
        check("rst_dat_samp_en", int'(dat_samp_en), 0);
        check("rst_P_DATA",      int'(P_DATA),      0);
        check("rst_data_valid",  int'(data_valid),  0);
        check("rst_par_err",     int'(par_err),     0);
        check("rst_stp_err",     int'(stp_err),     0);
        step();
        RST    = 1'b1;
        chk_on = 1'b1;
        idle(4);

        // Prescale 8, no parity, 0xA5
        clear_mon();
        step();
        send_frame(8, 0, 0, 8'hA5, 0, 1, 0, 0, t0);
        idle(4);
        check("a5_dv_time",  last_dv - t0, 81);
        check("a5_dv_count", dv_n, 1);
        check("a5_errors",   pe_n + se_n, 0);
        check("a5_pdata",    int'(P_DATA), 8'hA5);

        // Prescale 16, even parity, bad parity bit on 0x3C
        clear_mon();
        step();
        send_frame(16, 1, 0, 8'h3C, 1, 1, 0, 0, t0);
        idle(4);
        check("par_time",     last_pe - t0, 161);
        check("par_no_dv",    dv_n, 0);
        check("par_pdata",    int'(P_DATA), 8'hA5);

        // Prescale 32, stop bit low on 0x5A
        clear_mon();
        step();
        send_frame(32, 0, 0, 8'h5A, 0, 0, 0, 0, t0);
        idle(4);
        check("stp_time",  last_se - t0, 321);
        check("stp_no_dv", dv_n, 0);

        // Prescale 8, 3-cycle low glitch
        clear_mon();
        step();
        send_glitch(8, 3, t0);
        idle(4);
        check("glitch_active_cycles", en_n, 8);
        check("glitch_pulses", dv_n + pe_n + se_n, 0);

        // Prescale 8, back-to-back 0x01 then 0xFE
        clear_mon();
        step();
        send_frame(8, 0, 0, 8'h01, 0, 1, 1, 0, t0);
        send_frame(8, 0, 0, 8'hFE, 0, 1, 0, 0, t1);
        idle(4);
        check("b2b_dv_count", dv_n, 2);
        check("b2b_spacing",  last_dv - first_dv, 80);
        check("b2b_pdata",    int'(P_DATA), 8'hFE);

        // Reset mid-DATA, then 0x55
        step();
        send_frame(8, 1, 0, 8'h5A, 1, 1, 0, 29, t0);
        idle(4);
        clear_mon();
        step();
        send_frame(8, 0, 0, 8'h55, 0, 1, 0, 0, t0);
        idle(4);
        check("rst_rx_pdata",  int'(P_DATA), 8'h55);
        check("rst_rx_dv",     dv_n, 1);
        check("rst_rx_errors", pe_n + se_n, 0);
`ifdef UART_RX_ERR_CNT_EN
        check("rst_rx_err_cnt", int'(err_cnt), 0);
`endif

        // Randomized frames
        prev_b2b = 0;
        p = 8; pen = 0; ptyp = 0;
        for (int f = 0; f < 40 && cyc < MAXC - 800; f++) begin
            if (!prev_b2b) begin
                p    = pick_p();
                pen  = 1'($urandom % 2);
                ptyp = 1'($urandom % 2);
                step();
            end
            b2b = ($urandom % 4 == 0) && (f != 39);
            send_frame(p, pen, ptyp, 8'($urandom), ($urandom % 5 == 0),
                       ($urandom % 6 != 0), b2b, 0, t0);
            if (!b2b) idle(1 + $urandom % 5);
            prev_b2b = b2b;
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
